// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//
// Emits a run of values from a latched start value towards a latched end
// bound, moving by +/-step each element. The whole run can repeat for a set
// number of passes, or forever. Elements leave through a valid/ready
// handshake, so a stalled consumer freezes the sequence. An active sequence
// can be aborted.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   clk_enable        qualifies every state update
//   start, abort      start a sequence (IDLE only) / kill an active one
//   cfg_start/end     first value and terminal bound (latched on start)
//   cfg_step          step magnitude, 0 behaves as 1 (latched on start)
//   cfg_down          0 = count up, 1 = count down (latched on start)
//   cfg_loops         pass count, 0 = repeat until abort (latched on start)
//   out_ready         consumer accepts the current element
//   out, out_valid    current element and its valid flag
//   out_last          current element closes its pass
//   out_done          current element closes the final pass
//   busy              sequencer is in RUN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sequence; outputs cleared; waiting for start
// RUN   | presenting elements; out_valid is high throughout
// ---------------------------------------------------------------------------
module count_sequencer #(
    parameter int COUNT_WIDTH = 8,
    parameter int LOOP_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_enable,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] cfg_start,
    input  logic [COUNT_WIDTH-1:0] cfg_end,
    input  logic [COUNT_WIDTH-1:0] cfg_step,
    input  logic                   cfg_down,
    input  logic [LOOP_WIDTH-1:0]  cfg_loops,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] out,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   out_done,
    output logic                   busy
);

    localparam int W = COUNT_WIDTH;

    // One-hot style encoding leaves 2'b00 and 2'b11 as detectable illegal codes.
    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  out_done_q, out_done_d;
    logic [W-1:0]          start_q, start_d;
    logic [W-1:0]          end_q, end_d;
    logic [W-1:0]          step_q, step_d;
    logic                  down_q, down_d;
    logic                  infinite_q, infinite_d;
    logic [LOOP_WIDTH-1:0] loops_left_q, loops_left_d;

    logic                  transfer;
    logic [W-1:0]          cfg_step_eff;
    logic [W-1:0]          next_val;
    logic [LOOP_WIDTH-1:0] loops_nxt;
    logic                  last_tmp;

    // Compare in W+1 bits so v+step and end+step cannot wrap; this is what
    // keeps an overshooting step from ever emitting a value past the bound.
    function automatic logic is_last(input logic [W-1:0] v,
                                     input logic [W-1:0] e,
                                     input logic [W-1:0] s,
                                     input logic         dn);
        logic [W:0] ve, ee, se;
        ve = {1'b0, v};
        ee = {1'b0, e};
        se = {1'b0, s};
        if (!dn) is_last = (ve >= ee) || ((ve + se) > ee);
        else     is_last = (ve <= ee) || (ve < (ee + se));
    endfunction

    assign transfer     = clk_enable && out_valid_q && out_ready;
    assign cfg_step_eff = (cfg_step == '0) ? W'(1) : cfg_step;

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_done_d   = out_done_q;
        start_d      = start_q;
        end_d        = end_q;
        step_d       = step_q;
        down_d       = down_q;
        infinite_d   = infinite_q;
        loops_left_d = loops_left_q;
        next_val     = down_q ? (out_q - step_q) : (out_q + step_q);
        loops_nxt    = infinite_q ? loops_left_q : (loops_left_q - LOOP_WIDTH'(1));
        last_tmp     = 1'b0;

        if (clk_enable) begin
            case (state_q)
                S_IDLE: begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_done_d  = 1'b0;
                    if (start && !abort) begin
                        state_d      = S_RUN;
                        start_d      = cfg_start;
                        end_d        = cfg_end;
                        step_d       = cfg_step_eff;
                        down_d       = cfg_down;
                        infinite_d   = (cfg_loops == '0);
                        loops_left_d = cfg_loops;
                        last_tmp     = is_last(cfg_start, cfg_end, cfg_step_eff, cfg_down);
                        out_d        = cfg_start;
                        out_valid_d  = 1'b1;
                        out_last_d   = last_tmp;
                        out_done_d   = last_tmp && (cfg_loops == LOOP_WIDTH'(1));
                    end
                end

                S_RUN: begin
                    if (abort || (transfer && out_done_q)) begin
                        state_d     = S_IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_done_d  = 1'b0;
                    end else if (transfer && !out_last_q) begin
                        last_tmp   = is_last(next_val, end_q, step_q, down_q);
                        out_d      = next_val;
                        out_last_d = last_tmp;
                        out_done_d = last_tmp && !infinite_q &&
                                     (loops_left_q == LOOP_WIDTH'(1));
                    end else if (transfer) begin
                        // End of a non-final pass: restart with no bubble.
                        last_tmp     = is_last(start_q, end_q, step_q, down_q);
                        loops_left_d = loops_nxt;
                        out_d        = start_q;
                        out_last_d   = last_tmp;
                        out_done_d   = last_tmp && !infinite_q &&
                                       (loops_nxt == LOOP_WIDTH'(1));
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_done_q   <= 1'b0;
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            down_q       <= 1'b0;
            infinite_q   <= 1'b0;
            loops_left_q <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_done_q   <= out_done_d;
            start_q      <= start_d;
            end_q        <= end_d;
            step_q       <= step_d;
            down_q       <= down_d;
            infinite_q   <= infinite_d;
            loops_left_q <= loops_left_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_done  = out_done_q;
    assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
//
// Cycle-by-cycle directed bench. Each record holds the inputs driven before
// one clock edge and the outputs expected just after it.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

    localparam int CW = 8;
    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic          clk_enable;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_start;
    logic [CW-1:0] cfg_end;
    logic [CW-1:0] cfg_step;
    logic          cfg_down;
    logic [LW-1:0] cfg_loops;
    logic          out_ready;
    logic [CW-1:0] out;
    logic          out_valid;
    logic          out_last;
    logic          out_done;
    logic          busy;

    typedef struct {
        logic          rst;
        logic          en;
        logic          start;
        logic          abort;
        logic [CW-1:0] cs;
        logic [CW-1:0] ce;
        logic [CW-1:0] st;
        logic          dn;
        logic [LW-1:0] lp;
        logic          rdy;
        logic [CW-1:0] eo;
        logic          ev;
        logic          el;
        logic          ed;
        logic          eb;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;

    count_sequencer #(.COUNT_WIDTH(CW), .LOOP_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .start      (start),
        .abort      (abort),
        .cfg_start  (cfg_start),
        .cfg_end    (cfg_end),
        .cfg_step   (cfg_step),
        .cfg_down   (cfg_down),
        .cfg_loops  (cfg_loops),
        .out_ready  (out_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_done   (out_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int en, input int s, input int a,
                                input int cs, input int ce, input int st, input int dn,
                                input int lp, input int rdy,
                                input int eo, input int ev, input int el, input int ed,
                                input int eb);
        vec_t v;
        v.rst = 1'(r);    v.en = 1'(en);   v.start = 1'(s);  v.abort = 1'(a);
        v.cs  = CW'(cs);  v.ce = CW'(ce);  v.st = CW'(st);   v.dn = 1'(dn);
        v.lp  = LW'(lp);  v.rdy = 1'(rdy);
        v.eo  = CW'(eo);  v.ev = 1'(ev);   v.el = 1'(el);    v.ed = 1'(ed);
        v.eb  = 1'(eb);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [CW+3:0] got;
        logic [CW+3:0] exp;
        rst        = v.rst;
        clk_enable = v.en;
        start      = v.start;
        abort      = v.abort;
        cfg_start  = v.cs;
        cfg_end    = v.ce;
        cfg_step   = v.st;
        cfg_down   = v.dn;
        cfg_loops  = v.lp;
        out_ready  = v.rdy;
        @(posedge clk);
        #1;
        got = {out, out_valid, out_last, out_done, busy};
        exp = {v.eo, v.ev, v.el, v.ed, v.eb};
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got out=%0d valid=%b last=%b done=%b busy=%b, want out=%0d valid=%b last=%b done=%b busy=%b",
                      tag, idx, out, out_valid, out_last, out_done, busy,
                      v.eo, v.ev, v.el, v.ed, v.eb);
    endtask

    initial begin
        // reset, IDLE corner cases
        vq.push_back(mk(1,1,0,0,  0,  0,  0,0,0,1,   0,0,0,0,0));
        vq.push_back(mk(1,0,1,0,  5,  9,  1,0,1,1,   0,0,0,0,0));
        vq.push_back(mk(0,1,1,1,  5,  9,  1,0,1,1,   0,0,0,0,0)); // abort beats start
        vq.push_back(mk(0,0,1,0,  5,  9,  1,0,1,1,   0,0,0,0,0)); // start gated off
        vq.push_back(mk(0,1,0,1,  5,  9,  1,0,1,1,   0,0,0,0,0)); // abort in IDLE
        // basic up 2..10 step 3
        vq.push_back(mk(0,1,1,0,  2, 10,  3,0,1,1,   2,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  2, 10,  3,0,1,1,   5,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  2, 10,  3,0,1,1,   8,1,1,1,1));
        vq.push_back(mk(0,1,1,0,  2, 10,  3,0,1,1,   0,0,0,0,0)); // start on final edge ignored
        // down 9..3 step 2, two passes
        vq.push_back(mk(0,1,1,0,  9,  3,  2,1,2,1,   9,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   7,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   5,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   3,1,1,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   9,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   7,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   5,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   3,1,1,1,1));
        vq.push_back(mk(0,1,0,0,  9,  3,  2,1,2,1,   0,0,0,0,0));
        // step 0 behaves as 1
        vq.push_back(mk(0,1,1,0,  0,  2,  0,0,1,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,  2,  0,0,1,1,   1,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,  2,  0,0,1,1,   2,1,1,1,1));
        vq.push_back(mk(0,1,0,0,  0,  2,  0,0,1,1,   0,0,0,0,0));
        // start beyond end: single element
        vq.push_back(mk(0,1,1,0, 12,  4,  1,0,1,1,  12,1,1,1,1));
        vq.push_back(mk(0,1,0,0, 12,  4,  1,0,1,1,   0,0,0,0,0));
        // overshoot near the top of the range
        vq.push_back(mk(0,1,1,0,  0,255,100,0,1,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,255,100,0,1,1, 100,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,255,100,0,1,1, 200,1,1,1,1));
        vq.push_back(mk(0,1,0,0,  0,255,100,0,1,1,   0,0,0,0,0));
        // infinite mode and abort
        vq.push_back(mk(0,1,1,0,  0,  1,  1,0,0,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,  1,  1,0,0,1,   1,1,1,0,1));
        vq.push_back(mk(0,1,0,0,  0,  1,  1,0,0,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,  1,  1,0,0,1,   1,1,1,0,1));
        vq.push_back(mk(0,1,0,0,  0,  1,  1,0,0,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,1,1,  0,  1,  1,0,0,1,   0,0,0,0,0));
        vq.push_back(mk(0,1,1,0,  0,  1,  1,0,0,1,   0,1,0,0,1));
        vq.push_back(mk(0,1,0,0,  0,  1,  1,0,0,1,   1,1,1,0,1));
        vq.push_back(mk(0,1,0,1,  0,  1,  1,0,0,0,   0,0,0,0,0));

        foreach (vq[i]) apply(vq[i], "vec", i);

        // backpressure: hold on 1 for three stalled cycles
        apply(mk(0,1,1,0, 0,3,1,0,1,1, 0,1,0,0,1), "bp", 0);
        apply(mk(0,1,0,0, 0,3,1,0,1,1, 1,1,0,0,1), "bp", 1);
        for (int k = 0; k < 3; k++)
            apply(mk(0,1,0,0, 0,3,1,0,1,0, 1,1,0,0,1), "bp_stall", k);
        apply(mk(0,1,0,0, 0,3,1,0,1,1, 2,1,0,0,1), "bp", 2);
        apply(mk(0,1,0,0, 0,3,1,0,1,1, 3,1,1,1,1), "bp", 3);
        apply(mk(0,1,0,0, 0,3,1,0,1,1, 0,0,0,0,0), "bp", 4);

        // clk_enable toggling: each element lasts two cycles
        apply(mk(0,1,1,0, 0,2,1,0,1,1, 0,1,0,0,1), "gate", 0);
        for (int k = 1; k <= 2; k++) begin
            apply(mk(0,0,0,0, 0,2,1,0,1,1, k-1,1,0,0,1), "gate_hold", k);
            apply(mk(0,1,0,0, 0,2,1,0,1,1, k,1,(k==2),(k==2),1), "gate_step", k);
        end
        apply(mk(0,0,0,0, 0,2,1,0,1,1, 2,1,1,1,1), "gate_hold", 3);
        apply(mk(0,1,0,0, 0,2,1,0,1,1, 0,0,0,0,0), "gate_step", 3);

        // reset mid-sequence, with clk_enable low
        apply(mk(0,1,1,0, 0,5,1,0,1,1, 0,1,0,0,1), "rst", 0);
        apply(mk(0,1,0,0, 0,5,1,0,1,1, 1,1,0,0,1), "rst", 1);
        apply(mk(1,0,0,0, 0,5,1,0,1,1, 0,0,0,0,0), "rst", 2);
        apply(mk(0,1,0,0, 0,5,1,0,1,1, 0,0,0,0,0), "rst", 3);

        // cfg_end edited mid-run is ignored
        apply(mk(0,1,1,0, 0,3,1,0,1,1, 0,1,0,0,1), "cfg", 0);
        apply(mk(0,1,0,0, 0,1,1,0,1,1, 1,1,0,0,1), "cfg", 1);
        apply(mk(0,1,0,0, 0,1,1,0,1,1, 2,1,0,0,1), "cfg", 2);
        apply(mk(0,1,0,0, 0,1,1,0,1,1, 3,1,1,1,1), "cfg", 3);
        apply(mk(0,1,0,0, 0,1,1,0,1,1, 0,0,0,0,0), "cfg", 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Parametrised successor to the team's fixed-range counter. Emits a sequence of values from a runtime-configured start to end, in a configurable step and direction, with optional repetition. Output uses a valid/ready handshake so downstream blocks can stall it, and the sequence can be aborted. Typical uses are address sweeps, LED/pattern sequencers and test-pattern sources behind clk_enable strobes.

Parameters:
COUNT_WIDTH, 8, width of the count value and of the cfg_start, cfg_end and cfg_step fields.
LOOP_WIDTH, 4, width of cfg_loops; sets the maximum finite pass count to 2^LOOP_WIDTH-1.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high; acts regardless of clk_enable.
clk_enable  in  1  qualifies every state update; when low, all registers hold.
start  in  1  requests a new sequence; accepted only in IDLE.
abort  in  1  terminates an active sequence.
cfg_start  in  COUNT_WIDTH  first value; latched when start is accepted.
cfg_end  in  COUNT_WIDTH  terminal bound; latched when start is accepted.
cfg_step  in  COUNT_WIDTH  magnitude of the increment; 0 is treated as 1; latched when start is accepted.
cfg_down  in  1  0 = count up, 1 = count down; latched when start is accepted.
cfg_loops  in  LOOP_WIDTH  number of passes; 0 = repeat until abort; latched when start is accepted.
out_ready  in  1  downstream can accept the current element.
out  out  COUNT_WIDTH  current element.
out_valid  out  1  out is valid.
out_last  out  1  current element is the last of its pass.
out_done  out  1  current element is the last of the final pass.
busy  out  1  state is RUN.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out=0, out_valid=0, out_last=0, out_done=0, busy=0; all internal config and loop registers cleared.
- No register changes on a cycle where clk_enable=0, except on reset.
- Transfer: a transfer occurs on an edge where clk_enable && out_valid && out_ready.
- While out_valid && !transfer: out, out_last and out_done hold stable.
- States are IDLE and RUN. Any illegal state encoding returns to IDLE with outputs cleared.
- IDLE:
  - On start && !abort: latch the config, go to RUN.
  - On the next cycle: out=cfg_start, out_valid=1, busy=1, with out_last and out_done computed from that value.
  - Otherwise all outputs stay 0.
- Last-of-pass rule, using a (COUNT_WIDTH+1)-bit compare with no wrap:
  - Up: last when out >= end, or out + step > end.
  - Down: last when out <= end, or out - step < end (computed as out < end + step).
  - Consequence: if start is already at or beyond end in the count direction, the pass is a single element. Overshoot never emits a value past end.
- RUN, on a transfer of a non-last element: out advances by ±step on the next cycle. No bubble: back-to-back transfers are possible every enabled cycle.
- RUN, on a transfer of a last element, when passes remain (cfg_loops=0, or loops_left>1):
  - Decrement loops_left, unless the mode is infinite.
  - Next cycle: out=latched start, out_valid stays 1, no bubble.
- RUN, on a transfer of the final element (out_done=1): go to IDLE; next cycle out_valid=0, out=0, busy=0.
- out_done = out_last && (loops_left==1). It is never asserted when cfg_loops=0.
- abort, on an enabled edge in RUN: go to IDLE and clear the outputs, even if a transfer occurs on that same edge.
- abort in IDLE is ignored. abort takes priority over start on the same edge.
- start while in RUN is ignored; this includes the edge that transfers the final element. A new start is accepted only from IDLE, so at least one idle cycle separates sequences.
- Changes to the cfg_* inputs while in RUN have no effect.
- Reset mid-sequence takes effect on the next edge and discards the sequence.

Test Plan:
- Basic up count, out_ready=1, clk_enable=1: start with cfg_start=2, cfg_end=10, cfg_step=3, cfg_loops=1 -> out 2,5,8 on consecutive cycles; out_last and out_done high on 8; out_valid low the cycle after; busy falls with it.
- Down count with repeat: start=9, end=3, step=2, down=1, loops=2 -> 9,7,5,3,9,7,5,3; out_last on each 3; out_done only on the second 3.
- Backpressure: up sequence 0..3 step 1, with out_ready low for 3 cycles while out=1 -> out holds at 1 for those cycles; then 2,3; no element is skipped or duplicated.
- Corner cases:
  - step=0 treated as 1: 0..2 gives 0,1,2.
  - start=12 > end=4 in up mode gives a single element 12 with out_last and out_done set.
  - end=255 with step=100 at COUNT_WIDTH=8 gives 0,100,200, with last on 200 and no wrap.
- Abort and infinite mode: loops=0, 0..1 step 1 -> repeats 0,1,0,1 with out_done never set; abort asserted together with start and out_ready -> IDLE next cycle and that start is ignored; a later start is accepted normally.
- Gating and reset:
  - clk_enable toggling 1/0 stretches every element over 2 cycles with identical values.
  - rst asserted mid-sequence clears all outputs at the next edge.
  - Mid-RUN edits to cfg_end do not alter the running sequence.
